// File: rtl/sdram_demo_button_pio.sv
// Avalon-MM input PIO: synchronised button pins, sticky edge capture and a maskable level irq.
// Build option SDRAM_DEMO_BUTTON_PIO_DEBOUNCE_EN adds a per-bit stable-count debounce filter.
module sdram_demo_button_pio #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned EDGE_TYPE       = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] data_q, data_d, data_prev_q;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] rise, fall, edge_sel, captured, clr_mask, wdata;
  logic [31:0]      readdata_q, readdata_d;
  logic [1:0]       prime_q;
  logic             primed, wr_en;

  assign wdata  = writedata[WIDTH-1:0];
  assign wr_en  = chipselect & ~write_n;
  assign primed = (prime_q == 2'd3);

  if (WIDTH < 32) begin : g_wdata_upper
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

`ifdef SDRAM_DEMO_BUTTON_PIO_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] cnt_q [WIDTH];
  logic [CntW-1:0] cnt_d [WIDTH];

  // A pin change is accepted only after it has disagreed with data_q for DEBOUNCE_CYCLES clks.
  always_comb begin
    data_d = data_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == data_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        data_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  assign data_d = sync2_q;
`endif

  // While priming, data_prev follows the incoming filtered value so the pipeline filling up
  // after reset never looks like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      data_q      <= '0;
      data_prev_q <= '0;
      prime_q     <= 2'd0;
    end else begin
      sync1_q     <= in_port;
      sync2_q     <= sync1_q;
      data_q      <= data_d;
      data_prev_q <= primed ? data_q : data_d;
      prime_q     <= primed ? prime_q : prime_q + 2'd1;
    end
  end

  assign rise = data_q & ~data_prev_q;
  assign fall = ~data_q & data_prev_q;

  always_comb begin
    if (EDGE_TYPE == 0) begin
      edge_sel = rise;
    end else if (EDGE_TYPE == 1) begin
      edge_sel = fall;
    end else begin
      edge_sel = rise | fall;
    end
  end

  assign captured = primed ? edge_sel : '0;

  // Set beats clear so an edge arriving with a W1C on the same bit is never lost.
  always_comb begin
    clr_mask  = (wr_en && address == 2'd3) ? wdata : '0;
    irqmask_d = (wr_en && address == 2'd2) ? wdata : irqmask_q;
    edgecap_d = (edgecap_q & ~clr_mask) | captured;
  end

  always_comb begin
    readdata_d = '0;
    unique case (address)
      2'd0:    readdata_d[WIDTH-1:0] = data_q;
      2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edgecap_q  <= '0;
      irqmask_q  <= '0;
      readdata_q <= '0;
    end else begin
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule
